// File: rtl/sim_memory_model_sync_fifo.sv
// sim_memory_model_sync_fifo: single-clock FIFO with first-word-fall-through read data.
// Rev 1.0 - initial release.
`default_nettype none

module sim_memory_model_sync_fifo #(
  parameter int P_N       = 16,
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  output logic [P_DEPTH_N:0]   oCOUNT,
  input  logic                 iWR_EN,
  input  logic [P_N-1:0]       iWR_DATA,
  output logic                 oWR_FULL,
  input  logic                 iRD_EN,
  output logic [P_N-1:0]       oRD_DATA,
  output logic                 oRD_EMPTY
);

  logic [P_N-1:0]     r_mem [P_DEPTH];
  logic [P_DEPTH_N:0] r_wr_ptr;
  logic [P_DEPTH_N:0] r_rd_ptr;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[P_DEPTH_N-1:0] == r_rd_ptr[P_DEPTH_N-1:0]) &&
                   (r_wr_ptr[P_DEPTH_N] != r_rd_ptr[P_DEPTH_N]);

  assign w_push  = iWR_EN && !w_full;
  assign w_pop   = iRD_EN && !w_empty;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int i = 0; i < P_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr[P_DEPTH_N-1:0]] <= iWR_DATA;
    end
  end

  assign oCOUNT    = r_wr_ptr - r_rd_ptr;
  assign oWR_FULL  = w_full;
  assign oRD_EMPTY = w_empty;
  assign oRD_DATA  = r_mem[r_rd_ptr[P_DEPTH_N-1:0]];

endmodule

`default_nettype wire

// File: tb/tb_sim_memory_model_sync_fifo.sv
// Self-checking bench for sim_memory_model_sync_fifo against a queue-based reference.
`default_nettype none

module tb_sim_memory_model_sync_fifo;

  localparam int N     = 64;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    count;
  logic          wr_en;
  logic [N-1:0]  wr_data;
  logic          full;
  logic          rd_en;
  logic [N-1:0]  rd_data;
  logic          empty;

  int            n_pass = 0;
  int            n_total = 0;
  logic [N-1:0]  q[$];

  always #5 clk = ~clk;

  sim_memory_model_sync_fifo #(N, DEPTH, 3) dut (
    .iCLOCK    (clk),
    .inRESET   (rst_n),
    .oCOUNT    (count),
    .iWR_EN    (wr_en),
    .iWR_DATA  (wr_data),
    .oWR_FULL  (full),
    .iRD_EN    (rd_en),
    .oRD_DATA  (rd_data),
    .oRD_EMPTY (empty)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".count"}, {60'd0, count}, N'(q.size()));
    chk({tag, ".empty"}, {63'd0, empty}, N'(q.size() == 0));
    chk({tag, ".full"},  {63'd0, full},  N'(q.size() == DEPTH));
  endtask

  // One clock cycle: called just after a falling edge, returns just after the next one.
  task automatic step(input logic w, input logic [N-1:0] d, input logic r);
    bit was_full, was_empty;
    wr_en = w; wr_data = d; rd_en = r;
    #1;
    if (q.size() != 0) chk("fwft_data", rd_data, q[0]);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk);
    if (r && !was_empty) void'(q.pop_front());
    if (w && !was_full)  q.push_back(d);
    #1;
    chk_flags("post_edge");
    if (count > 4'd8) chk("count_bound", {60'd0, count}, 64'd8);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk_flags("async_reset");
    chk("reset_data", rd_data, '0);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    #2;
    chk_flags("reset");
    chk("reset_data", rd_data, '0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Fill, then a dropped push while full.
    for (int i = 1; i <= 8; i++) step(1'b1, N'(i * 'h11), 1'b0);
    chk("fill_count", {60'd0, count}, 64'd8);
    chk("fill_full", {63'd0, full}, 64'd1);
    step(1'b1, 64'h99, 1'b0);
    chk("drop_count", {60'd0, count}, 64'd8);

    // FWFT drain with explicit data values, then pop on empty.
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b0; rd_en = 1'b1;
      #1 chk("drain_data", rd_data, N'(i * 'h11));
      @(negedge clk);
      void'(q.pop_front());
    end
    rd_en = 1'b0;
    #1 chk_flags("drained");
    step(1'b0, '0, 1'b1);

    // Simultaneous push+pop at count 3.
    for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom}, 1'b0);
    step(1'b1, 64'hAA, 1'b1);
    chk("pp_count", {60'd0, count}, 64'd3);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

    // Push+pop while empty: push only.
    step(1'b1, 64'h5, 1'b1);
    chk("empty_pp_count", {60'd0, count}, 64'd1);
    chk("empty_pp_data", rd_data, 64'h5);
    step(1'b0, '0, 1'b1);

    // Push+pop while full: push dropped, pop happens.
    for (int i = 0; i < 8; i++) step(1'b1, {$urandom, $urandom}, 1'b0);
    step(1'b1, 64'hDEAD, 1'b1);
    chk("full_pp_count", {60'd0, count}, 64'd7);

    // Randomised traffic across many pointer wraps.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));

    // Mid-stream asynchronous reset, then traffic resumes.
    for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    async_reset();
    for (int i = 0; i < 20; i++) step(1'b1, {$urandom, $urandom}, 1'b1);
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
